// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequence generator.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_STREAM = 1'b1;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci advance: (a, b) -> (b, a+b) with sticky overflow propagation.
module fib_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_ovf,
    input  logic             b_ovf,
    output logic [WIDTH-1:0] a_next_c,
    output logic [WIDTH-1:0] b_next_c,
    output logic             a_ovf_next_c,
    output logic             b_ovf_next_c
);

    logic [WIDTH:0] sum_c;

    // The sum may wrap once a flag is set; the flag, not the data, is authoritative.
    always_comb begin
        sum_c        = {1'b0, a} + {1'b0, b};
        a_next_c     = b;
        b_next_c     = sum_c[WIDTH-1:0];
        a_ovf_next_c = b_ovf;
        b_ovf_next_c = a_ovf | b_ovf | sum_c[WIDTH];
    end

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci generator: single-result or streamed F(0)..F(n) over valid/ready,
// with saturation and an overflow flag for terms wider than WIDTH.
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned IDX_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [IDX_WIDTH-1:0] index,
    input  logic                 abort,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [IDX_WIDTH-1:0] out_index,
    output logic                 out_last,
    output logic                 overflow,
    output logic                 done
);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
    logic                  a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
    logic [IDX_WIDTH-1:0]  k_q, k_d, n_q, n_d;
    logic                  mode_q, mode_d;

    logic                  busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic [IDX_WIDTH-1:0]  out_index_q, out_index_d;
    logic                  out_last_q, out_last_d;
    logic                  overflow_q, overflow_d;
    logic                  done_q, done_d;

    logic                  is_last_c;
    logic                  advance_c;
    logic [WIDTH-1:0]      a_next_c, b_next_c;
    logic                  a_ovf_next_c, b_ovf_next_c;

    fib_step #(.WIDTH(WIDTH)) u_step (
        .a            (a_q),
        .b            (b_q),
        .a_ovf        (a_ovf_q),
        .b_ovf        (b_ovf_q),
        .a_next_c     (a_next_c),
        .b_next_c     (b_next_c),
        .a_ovf_next_c (a_ovf_next_c),
        .b_ovf_next_c (b_ovf_next_c)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        a_ovf_d   = a_ovf_q;
        b_ovf_d   = b_ovf_q;
        k_d       = k_q;
        n_d       = n_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        advance_c = 1'b0;
        is_last_c = (mode_q == MODE_SINGLE) || (k_q == n_q);

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = (mode == MODE_STREAM) ? OUT : RUN;
                    a_d     = '0;
                    b_d     = WIDTH'(1);
                    a_ovf_d = 1'b0;
                    b_ovf_d = 1'b0;
                    k_d     = '0;
                    n_d     = index;
                    mode_d  = mode;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (k_q == n_q) begin
                    state_d = OUT;
                end else begin
                    advance_c = 1'b1;
                end
            end
            OUT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (is_last_c) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        advance_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (advance_c) begin
            a_d     = a_next_c;
            b_d     = b_next_c;
            a_ovf_d = a_ovf_next_c;
            b_ovf_d = b_ovf_next_c;
            k_d     = k_q + IDX_WIDTH'(1);
        end

        // Outputs mirror the state being entered so they are valid from a flop.
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == OUT);
        out_data_d  = out_valid_d ? (a_ovf_d ? '1 : a_d) : '0;
        out_index_d = out_valid_d ? k_d : '0;
        out_last_d  = out_valid_d && ((mode_d == MODE_SINGLE) || (k_d == n_d));
        overflow_d  = out_valid_d && a_ovf_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            a_ovf_q     <= 1'b0;
            b_ovf_q     <= 1'b0;
            k_q         <= '0;
            n_q         <= '0;
            mode_q      <= MODE_SINGLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            a_ovf_q     <= a_ovf_d;
            b_ovf_q     <= b_ovf_d;
            k_q         <= k_d;
            n_q         <= n_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Bench for fib_seq_gen: directed and random requests checked against an
// arithmetic Fibonacci reference, plus an 8-bit instance for saturation.
module tb_fib_seq_gen;

    localparam int unsigned W   = 16;
    localparam int unsigned IW  = 5;
    localparam int unsigned W2  = 8;
    localparam int unsigned IW2 = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start, mode, abort, out_ready;
    logic [IW-1:0] index;
    logic          busy, out_valid, out_last, overflow, done;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_index;

    logic           s_start, s_mode, s_abort, s_ready;
    logic [IW2-1:0] s_index;
    logic           s_busy, s_valid, s_last, s_ovf, s_done;
    logic [W2-1:0]  s_data;
    logic [IW2-1:0] s_idx;

    int tests  = 0;
    int failed = 0;

    fib_seq_gen #(.WIDTH(W), .IDX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .index(index),
        .abort(abort), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .overflow(overflow), .done(done)
    );

    fib_seq_gen #(.WIDTH(W2), .IDX_WIDTH(IW2)) dut8 (
        .clk(clk), .reset(reset), .start(s_start), .mode(s_mode), .index(s_index),
        .abort(s_abort), .busy(s_busy), .out_valid(s_valid), .out_ready(s_ready),
        .out_data(s_data), .out_index(s_idx), .out_last(s_last),
        .overflow(s_ovf), .done(s_done)
    );

    function automatic logic [63:0] fib_ref(input int n);
        logic [63:0] x, y, t;
        x = 64'd0;
        y = 64'd1;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [63:0] sat_ref(input int n, input int w);
        logic [63:0] lim;
        lim = (64'd1 << w) - 64'd1;
        return (fib_ref(n) > lim) ? lim : fib_ref(n);
    endfunction

    function automatic logic ovf_ref(input int n, input int w);
        return fib_ref(n) > ((64'd1 << w) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input int n);
        int cyc;
        start = 1'b1; mode = 1'b0; index = IW'(n); out_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("single_latency", 64'(cyc), 64'(n + 2));
        check("single_data", 64'(out_data), sat_ref(n, W));
        check("single_index", 64'(out_index), 64'(n));
        check("single_last", 64'(out_last), 64'd1);
        check("single_ovf", 64'(overflow), 64'(ovf_ref(n, W)));
        tick();
        check("single_done", 64'(done), 64'd1);
        check("single_busy_after", 64'(busy), 64'd0);
    endtask

    // pat: 0 = ready held high, 1 = ready toggling 1,0,1,..., 2 = random ready
    task automatic run_stream(input int n, input int pat);
        int k, cyc, dones, bound;
        logic rdy;
        k = 0; cyc = 1; dones = 0; bound = 4 * n + 20;
        start = 1'b1; mode = 1'b1; index = IW'(n);
        tick();
        start = 1'b0;
        while (k <= n && cyc < bound) begin
            if (pat == 0)      rdy = 1'b1;
            else if (pat == 1) rdy = ((cyc - 1) % 2 == 0);
            else               rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            check("strm_valid", 64'(out_valid), 64'd1);
            check("strm_data", 64'(out_data), sat_ref(k, W));
            check("strm_index", 64'(out_index), 64'(k));
            check("strm_last", 64'(out_last), 64'(k == n));
            check("strm_ovf", 64'(overflow), 64'(ovf_ref(k, W)));
            if (pat == 0) check("strm_latency", 64'(cyc), 64'(k + 1));
            dones += int'(done);
            tick();
            cyc++;
            if (rdy) k++;
        end
        check("strm_terms", 64'(k), 64'(n + 1));
        check("strm_done", 64'(done), 64'd1);
        if (pat == 0) check("strm_done_cycle", 64'(cyc), 64'(n + 2));
        dones += int'(done);
        out_ready = 1'b0;
        tick();
        dones += int'(done);
        check("strm_done_count", 64'(dones), 64'd1);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b0; mode = 1'b0; index = '0; abort = 1'b0; out_ready = 1'b0;
        s_start = 1'b0; s_mode = 1'b0; s_index = '0; s_abort = 1'b0; s_ready = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_index", 64'(out_index), 64'd0);
        @(negedge clk) reset = 1'b1;
        tick();

        run_single(10);
        run_single(0);
        run_single(1);
        run_single(24);
        run_single(25);
        run_stream(5, 1);
        run_stream(26, 0);
        run_stream(7, 2);

        // start while busy must not disturb the request in flight
        start = 1'b1; mode = 1'b0; index = IW'(10); out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; mode = 1'b1; index = IW'(3);
        tick();
        start = 1'b0;
        cyc = 4;
        while (!out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("busy_start_latency", 64'(cyc), 64'd12);
        check("busy_start_data", 64'(out_data), 64'd55);
        check("busy_start_index", 64'(out_index), 64'd10);
        tick();
        check("busy_start_done", 64'(done), 64'd1);

        // abort in OUT with ready high
        start = 1'b1; mode = 1'b1; index = IW'(5); out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort_pre_index", 64'(out_index), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        tick();
        check("abort_done_later", 64'(done), 64'd0);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; mode = 1'b0; index = IW'(2);
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);
        tick();
        check("start_abort_valid", 64'(out_valid), 64'd0);

        // asynchronous reset mid-stream
        start = 1'b1; mode = 1'b1; index = IW'(20); out_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_index", 64'(out_index), 64'd0);
        check("mid_rst_last", 64'(out_last), 64'd0);
        @(negedge clk) reset = 1'b1;
        tick();
        check("post_rst_done", 64'(done), 64'd0);
        run_single(3);

        // random requests
        for (int r = 0; r < 16; r++) begin
            int n;
            n = int'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) run_single(n);
            else                           run_stream(n, 2);
        end

        // narrow instance: saturation from F(14)=377 at WIDTH=8
        s_start = 1'b1; s_mode = 1'b1; s_index = IW2'(15); s_ready = 1'b1;
        tick();
        s_start = 1'b0;
        for (int k = 0; k <= 15; k++) begin
            check("w8_valid", 64'(s_valid), 64'd1);
            check("w8_data", 64'(s_data), sat_ref(k, W2));
            check("w8_ovf", 64'(s_ovf), 64'(ovf_ref(k, W2)));
            check("w8_index", 64'(s_idx), 64'(k));
            check("w8_last", 64'(s_last), 64'(k == 15));
            tick();
        end
        check("w8_done", 64'(s_done), 64'd1);
        check("w8_busy", 64'(s_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised Fibonacci sequence generator: the next generation of the team's fixed 16-bit Fibonacci number generator. It computes F(n), with F(0)=0 and F(1)=1, for a runtime index n. Width and index range are set by parameters. Two modes:
- single mode returns only F(n);
- stream mode emits F(0)..F(n) over a valid/ready output channel.

Terms that exceed the data width saturate and are flagged. The block sits between a request source (start/index) and a downstream consumer (valid/ready).

## Interface
- WIDTH, 16, data width of each term; must be ≥ 2
- IDX_WIDTH, 5, width of index n; must be ≥ 1
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; clears all state
- start  input  1  request strobe; sampled only in IDLE
- mode  input  1  0 = single, 1 = stream; latched with start
- index  input  IDX_WIDTH  n; latched with start
- abort  input  1  synchronous cancel; returns to IDLE next cycle, no done pulse
- busy  output  1  high in any state except IDLE
- out_valid  output  1  out_data is presented
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_data  output  WIDTH  F(k), or all-ones if saturated
- out_index  output  IDX_WIDTH  k of the presented term
- out_last  output  1  high with out_valid when k == n
- overflow  output  1  presented term does not fit in WIDTH bits
- done  output  1  one-cycle pulse after the final handshake

## Operation
- Registers:
  - a = F(k) and b = F(k+1), each WIDTH bits;
  - sticky flags a_ovf and b_ovf;
  - k (IDX_WIDTH bits);
  - latched n and mode.
- States: IDLE, RUN, OUT.
- IDLE:
  - On start, load a=0, b=1, a_ovf=b_ovf=0, k=0, and latch n and mode.
  - Next state is RUN if mode=0, OUT if mode=1.
- RUN (single mode only):
  - If k == n, go to OUT.
  - Otherwise advance: a←b, b←a+b, a_ovf←b_ovf, b_ovf←a_ovf|b_ovf|carry, k←k+1.
- OUT:
  - out_valid=1.
  - out_data = a_ovf ? all-ones : a.
  - overflow = a_ovf.
  - out_last = (k == n) in stream mode; always 1 in single mode.
- Handshake in OUT:
  - If the term is last, go to IDLE and pulse done in that first IDLE cycle.
  - Otherwise (stream mode), advance as in RUN and stay in OUT. The next term is valid the following cycle.
- Saturation: once a term overflows, every later term is flagged. Adder inputs may wrap, but the flag governs the output.
- out_valid, once high, stays high with stable data until handshake. Exception: abort or reset.
- abort takes priority over handshake in the same cycle. done is not pulsed.
- start while busy=1 is ignored. It is not queued.
- start and abort together in IDLE: abort wins and no request is accepted.

## Timing
- Reset values:
  - busy=0, out_valid=0, out_last=0, overflow=0, done=0;
  - out_data=0, out_index=0;
  - state=IDLE.
- Reset mid-operation clears all state asynchronously. No done pulse is produced.
- Single mode: start accepted at cycle 0 gives out_valid high at cycle n+2, including n=0.
- Stream mode: F(0) is valid at cycle 1. With out_ready held high, term k is valid at cycle k+1 and done pulses at cycle n+2.
- After done, busy=0 and start is accepted the same cycle.
- Zero-bubble throughput in stream mode under continuous ready.

## Structure
- Shared package fib_pkg holds:
  - state typedef (IDLE, RUN, OUT);
  - mode constants MODE_SINGLE=0 and MODE_STREAM=1.
- Sub-module fib_step: combinational WIDTH-bit adder producing next a, b and overflow flags from current a, b and flags. RUN and OUT both use this one instance.
- Top-level fib_seq_gen holds the FSM, registers and output logic.

## Test plan
- WIDTH=16, single mode, n=10, out_ready=1 → out_data=55, out_index=10, out_last=1 at cycle 12; done at cycle 13; overflow=0.
- Single mode, n=0 → out_data=0 at cycle 2. Then n=1 → out_data=1 at cycle 3.
- Stream mode, n=5, out_ready toggling 1,0,1,0… → sequence 0,1,1,2,3,5 with out_last only on 5. Data is stable while stalled and there is exactly one done pulse.
- WIDTH=16, single mode:
  - n=24 → 46368, overflow=0;
  - n=25 → 0xFFFF, overflow=1;
  - stream mode, n=26 → terms 25 and 26 flagged and saturated.
- Robustness:
  - start pulsed during busy → ignored, current result unchanged;
  - abort in OUT with out_ready=1 → IDLE next cycle, no done;
  - reset asserted mid-stream → all outputs return to reset values immediately.
- Parameter sweep with WIDTH=8 and IDX_WIDTH=4, stream mode, n=15 → saturation from F(14)=377; F(13)=233 unflagged.
